pl_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Drives write-enable (WEN) and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus PC write-enable.
- Resolves I-miss, D-miss, load-use and taken-branch/jump hazards, and latches the halt condition.
- Keeps saturating stall and flush counters for performance observation.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/pl_sat_cnt.sv | 25 ++
 rtl/pl_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pl_hazard_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage core: register index, hazard-controller state
// and the latch-control bundles driven by the sequencing controller.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } hz_wen_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
  } hz_flush_t;

  localparam hz_wen_t   HZ_WEN_ALL  = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};
  localparam hz_wen_t   HZ_WEN_NONE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0};
  localparam hz_flush_t HZ_FLUSH_NONE = '{ifid: 1'b0, idex: 1'b0, exmem: 1'b0};

endpackage

// File: rtl/pl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pl_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_one;

  assign w_one = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_clear)                r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + w_one;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline sequencing controller: latch enables/flushes and PC enable from
// I-miss, D-miss, load-use, redirect and halt, plus saturating perf counters.
module pl_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             idex_dren,
  input  regbits_t         idex_rt,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t r_state, w_nxt;
  logic      r_halted;
  logic      w_dstall, w_lu, w_halt_dec, w_redir_take;
  hz_wen_t   w_wen;
  hz_flush_t w_flush;

  assign w_dstall   = (mem_dren | mem_dwen) & ~dhit;
  assign w_lu       = idex_dren & (idex_rt != '0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  assign w_halt_dec = (r_state == HALT) | wb_halt;

  // Leaving DWAIT keys off the stall clearing, so a dropped request can't strand us.
  always_comb begin
    w_nxt = r_state;
    if (w_halt_dec)                          w_nxt = HALT;
    else if ((r_state == RUN) && w_dstall)   w_nxt = DWAIT;
    else if ((r_state == DWAIT) && !w_dstall) w_nxt = RUN;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_halted <= r_halted | (w_nxt == HALT);
    end
  end

  // Priority decode: halt > D-miss > redirect > load-use > I-miss > run.
  always_comb begin
    w_wen        = HZ_WEN_ALL;
    w_flush      = HZ_FLUSH_NONE;
    w_redir_take = 1'b0;
    if (w_halt_dec) begin
      w_wen = HZ_WEN_NONE;
    end else if (w_dstall) begin
      w_wen = HZ_WEN_NONE;
    end else if (ex_redirect) begin
      w_flush.ifid = 1'b1;
      w_flush.idex = 1'b1;
      w_redir_take = 1'b1;
    end else if (w_lu) begin
      w_wen.pc     = 1'b0;
      w_wen.ifid   = 1'b0;
      w_flush.idex = 1'b1;
    end else if (!ihit) begin
      w_wen.pc     = 1'b0;
      w_flush.ifid = 1'b1;
    end
  end

  assign pc_wen      = w_wen.pc;
  assign ifid_wen    = w_wen.ifid;
  assign idex_wen    = w_wen.idex;
  assign exmem_wen   = w_wen.exmem;
  assign memwb_wen   = w_wen.memwb;
  assign ifid_flush  = w_flush.ifid;
  assign idex_flush  = w_flush.idex;
  assign exmem_flush = w_flush.exmem;
  assign state       = r_state;
  assign halted      = r_halted;

  pl_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_inc   (~w_wen.pc & (r_state != HALT)),
    .i_clear (1'b0),
    .o_cnt   (stall_cnt)
  );

  pl_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_inc   (w_redir_take),
    .i_clear (1'b0),
    .o_cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed scoreboard bench for pl_hazard_ctrl; a 4-bit-counter instance
// shares the stimulus to exercise counter saturation.
module tb_pl_hazard_ctrl;

  localparam logic [7:0] NRM = 8'b1111_1000;
  localparam logic [7:0] IMS = 8'b0111_1100;
  localparam logic [7:0] STL = 8'b0000_0000;
  localparam logic [7:0] RDR = 8'b1111_1110;
  localparam logic [7:0] LUC = 8'b0011_1010;

  logic       CLK, nRST;
  logic       ihit, dhit, mem_dren, mem_dwen, idex_dren, ex_redirect, wb_halt;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic        a_pc, a_ifw, a_idw, a_exw, a_mww, a_iff, a_idf, a_exf, a_hl;
  logic [1:0]  a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ifw, b_idw, b_exw, b_mww, b_iff, b_idf, b_exf, b_hl;
  logic [1:0]  b_st;
  logic [3:0]  b_sc, b_fc;

  typedef struct {
    logic [7:0] ctl;
    logic [1:0] st;
    logic       hl;
    int         s;
    int         f;
    int         s4;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntot  = 0;

  pl_hazard_ctrl u16 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren),
    .mem_dwen(mem_dwen), .idex_dren(idex_dren), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect),
    .wb_halt(wb_halt), .pc_wen(a_pc), .ifid_wen(a_ifw), .idex_wen(a_idw),
    .exmem_wen(a_exw), .memwb_wen(a_mww), .ifid_flush(a_iff),
    .idex_flush(a_idf), .exmem_flush(a_exf), .state(a_st), .halted(a_hl),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pl_hazard_ctrl #(.CNT_W(4)) u4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren),
    .mem_dwen(mem_dwen), .idex_dren(idex_dren), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect),
    .wb_halt(wb_halt), .pc_wen(b_pc), .ifid_wen(b_ifw), .idex_wen(b_idw),
    .exmem_wen(b_exw), .memwb_wen(b_mww), .ifid_flush(b_iff),
    .idex_flush(b_idf), .exmem_flush(b_exf), .state(b_st), .halted(b_hl),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl", int'({a_pc, a_ifw, a_idw, a_exw, a_mww, a_iff, a_idf, a_exf}), int'(e.ctl));
      chk("state", int'(a_st), int'(e.st));
      chk("halted", int'(a_hl), int'(e.hl));
      if (e.s  >= 0) chk("stall_cnt", int'(a_sc), e.s);
      if (e.f  >= 0) chk("flush_cnt", int'(a_fc), e.f);
      if (e.s4 >= 0) chk("stall_cnt4", int'(b_sc), e.s4);
    end
  end

  task automatic step(input logic rn, ih, dh, mr, mw, ld,
                      input logic [4:0] rt, rs, rtf,
                      input logic rd, wh,
                      input logic [7:0] ctl, input logic [1:0] st, input logic hl,
                      input int s, f, s4);
    exp_t e;
    @(posedge CLK); #1;
    nRST = rn; ihit = ih; dhit = dh; mem_dren = mr; mem_dwen = mw;
    idex_dren = ld; idex_rt = rt; ifid_rs = rs; ifid_rt = rtf;
    ex_redirect = rd; wb_halt = wh;
    e.ctl = ctl; e.st = st; e.hl = hl; e.s = s; e.f = f; e.s4 = s4;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; ihit = 0; dhit = 0; mem_dren = 0; mem_dwen = 0; idex_dren = 0;
    idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ex_redirect = 0; wb_halt = 0;

    // reset state, all inputs low
    step(0, 0,0,0,0,0, 0,0,0, 0,0, IMS,2'd0,0, 0,0,0);
    for (int i = 0; i < 10; i++)
      step(1, 1,0,0,0,0, 0,0,0, 0,0, NRM,2'd0,0, 0,0,0);

    // load miss for 3 cycles; redirect + I-miss inside DWAIT are held
    step(1, 1,0,1,0,0, 0,0,0, 0,0, STL,2'd0,0, 0,0,0);
    step(1, 0,0,1,0,0, 0,0,0, 1,0, STL,2'd1,0, 1,0,1);
    step(1, 1,0,1,0,0, 0,0,0, 0,0, STL,2'd1,0, 2,0,2);
    step(1, 1,1,1,0,0, 0,0,0, 0,0, NRM,2'd1,0, 3,0,3);
    step(1, 1,0,0,0,0, 0,0,0, 0,0, NRM,2'd0,0, 3,0,3);

    // load-use on rs, on rt, with rt=0, and coinciding with I-miss
    step(1, 1,0,0,0,1, 8,8,0, 0,0, LUC,2'd0,0, 3,0,3);
    step(1, 1,0,0,0,1, 8,0,8, 0,0, LUC,2'd0,0, 4,0,4);
    step(1, 1,0,0,0,1, 0,0,0, 0,0, NRM,2'd0,0, 5,0,5);
    step(1, 0,0,0,0,1, 8,8,0, 0,0, LUC,2'd0,0, 5,0,5);

    // redirect overrides load-use and I-miss
    step(1, 0,0,0,0,1, 8,8,0, 1,0, RDR,2'd0,0, 6,0,6);
    step(1, 1,0,0,0,0, 0,0,0, 0,0, NRM,2'd0,0, 6,1,6);

    // plain I-miss, then a store miss
    step(1, 0,0,0,0,0, 0,0,0, 0,0, IMS,2'd0,0, 6,1,6);
    step(1, 1,0,0,1,0, 0,0,0, 0,0, STL,2'd0,0, 7,1,7);
    step(1, 1,1,0,1,0, 0,0,0, 0,0, NRM,2'd1,0, 8,1,8);
    step(1, 1,0,0,0,0, 0,0,0, 0,0, NRM,2'd0,0, 8,1,8);

    // halt during a D-miss, then HALT absorbs a redirect
    step(1, 1,0,1,0,0, 0,0,0, 0,1, STL,2'd0,0, 8,1,8);
    for (int i = 0; i < 3; i++)
      step(1, 1,0,0,0,0, 0,0,0, 1,0, STL,2'd2,1, -1,1,-1);

    // async reset pulse clears everything
    step(0, 1,0,0,0,0, 0,0,0, 0,0, NRM,2'd0,0, 0,0,0);

    // continuous I-miss: 4-bit counter saturates at 15
    for (int k = 0; k <= 20; k++)
      step(1, 0,0,0,0,0, 0,0,0, 0,0, IMS,2'd0,0, k,0,(k > 15) ? 15 : k);
    step(1, 1,0,0,0,0, 0,0,0, 0,0, NRM,2'd0,0, 21,0,15);

    repeat (2) @(negedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
